// File: rtl/sa_seq_pkg.sv
// Shared types and helpers for the systolic-array host sequencer.
// Holds the FSM state encoding, default parameter values and the
// counter-width helper used to size the beat, readback, job and timeout counters.
package sa_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_AB   = 3'd1,
    START     = 3'd2,
    WAIT_DONE = 3'd3,
    RD_REQ    = 3'd4,
    RD_CAP    = 3'd5,
    RD_PUSH   = 3'd6
  } state_t;

  localparam int DEF_DATA_W      = 16;
  localparam int DEF_DIM         = 8;
  localparam int DEF_OUT_DEPTH   = 256;
  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_INST_W      = 6;
  localparam int DEF_INST_DEPTH  = 16;
  localparam int DEF_TIMEOUT_CYC = 4096;

  // Bits needed to hold the values 0..n-1 (never less than one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sa_host_sequencer_if.sv
// Bus bundle between the host sequencer and its neighbours: the command and
// operand streams in, the top's load/read/handshake ports, and the readback
// stream out. master = sequencer side, slave = host/top/sink side.
//
// Handshake rule for cmd, s and m streams: a beat transfers on a rising clock
// edge where valid and ready are both high; a source must hold valid and its
// payload stable until that edge, and ready never depends on valid.
interface sa_host_sequencer_if
  import sa_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int INST_W = DEF_INST_W
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [INST_W-1:0] cmd_inst;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data_a;
  logic [DATA_W-1:0] s_data_b;
  logic [ADDR_W-1:0] addr_A;
  logic [ADDR_W-1:0] addr_B;
  logic [ADDR_W-1:0] addr_I;
  logic [ADDR_W-1:0] addr_O;
  logic              en_A;
  logic              en_B;
  logic              en_I;
  logic              en_O;
  logic [DATA_W-1:0] data_A;
  logic [DATA_W-1:0] data_B;
  logic [INST_W-1:0] data_I;
  logic [DATA_W-1:0] data_O;
  logic              out_valid;
  logic              ap_start;
  logic              ap_done;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_ok;
  logic              m_last;
  logic              busy;
  logic              err;

  modport master (
    input  cmd_valid, cmd_inst, s_valid, s_data_a, s_data_b,
           data_O, out_valid, ap_done, m_ready,
    output cmd_ready, s_ready, addr_A, addr_B, addr_I, addr_O,
           en_A, en_B, en_I, en_O, data_A, data_B, data_I,
           ap_start, m_valid, m_data, m_ok, m_last, busy, err
  );

  modport slave (
    output cmd_valid, cmd_inst, s_valid, s_data_a, s_data_b,
           data_O, out_valid, ap_done, m_ready,
    input  cmd_ready, s_ready, addr_A, addr_B, addr_I, addr_O,
           en_A, en_B, en_I, en_O, data_A, data_B, data_I,
           ap_start, m_valid, m_data, m_ok, m_last, busy, err
  );

endinterface

// File: rtl/sa_seq_timeout.sv
// Loadable down-counter. o_expire pulses in the enabled cycle where the count
// is 1, i.e. after exactly i_load_val enabled cycles following the load.
module sa_seq_timeout #(
  parameter int CNT_W = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_cnt;

  // Load has priority; count down only while enabled and not yet empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = i_en && (r_cnt == CNT_W'(1));

endmodule

// File: rtl/sa_host_sequencer.sv
// Host-side job sequencer for the systolic-array top: takes a command and a
// DIM*DIM A/B operand stream, writes the I/A/B memories, runs the
// ap_start/ap_done handshake with a completion timeout, then streams the
// OUT_DEPTH-word output buffer back with backpressure.
// Optional build macro SA_SEQ_PERF_EN adds perf_cycles/perf_jobs counters.
module sa_host_sequencer
  import sa_seq_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DIM         = DEF_DIM,
  parameter int OUT_DEPTH   = DEF_OUT_DEPTH,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int INST_W      = DEF_INST_W,
  parameter int INST_DEPTH  = DEF_INST_DEPTH,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sa_host_sequencer_if.master  bus,
  output state_t               o_dbg_state
`ifdef SA_SEQ_PERF_EN
  , output logic [31:0]        perf_cycles
  , output logic [15:0]        perf_jobs
`endif
);

  localparam int NBEAT  = DIM * DIM;
  localparam int BEAT_W = cnt_w(NBEAT);
  localparam int RD_W   = cnt_w(OUT_DEPTH);
  localparam int JOB_W  = cnt_w(INST_DEPTH);
  localparam int TMO_W  = cnt_w(TIMEOUT_CYC + 1);

  if (NBEAT > (1 << ADDR_W)) begin : g_bad_dim
    $fatal(1, "sa_host_sequencer: DIM*DIM does not fit in ADDR_W address bits");
  end
  if (OUT_DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $fatal(1, "sa_host_sequencer: OUT_DEPTH does not fit in ADDR_W address bits");
  end

  state_t              r_state, w_nxt_state;
  logic                r_alive;
  logic                r_en_I, w_nxt_en_I;
  logic [ADDR_W-1:0]   r_addr_I, w_nxt_addr_I;
  logic [INST_W-1:0]   r_data_I, w_nxt_data_I;
  logic                r_en_AB, w_nxt_en_AB;
  logic [ADDR_W-1:0]   r_addr_AB, w_nxt_addr_AB;
  logic [DATA_W-1:0]   r_data_A, w_nxt_data_A;
  logic [DATA_W-1:0]   r_data_B, w_nxt_data_B;
  logic                r_en_O, w_nxt_en_O;
  logic [ADDR_W-1:0]   r_addr_O, w_nxt_addr_O;
  logic                r_ap_start, w_nxt_ap_start;
  logic                r_m_valid, w_nxt_m_valid;
  logic [DATA_W-1:0]   r_m_data, w_nxt_m_data;
  logic                r_m_ok, w_nxt_m_ok;
  logic                r_m_last, w_nxt_m_last;
  logic                r_err, w_nxt_err;
  logic [JOB_W-1:0]    r_job_idx, w_nxt_job_idx;
  logic [BEAT_W-1:0]   r_beat, w_nxt_beat;
  logic [RD_W-1:0]     r_rd_idx, w_nxt_rd_idx;
  logic                w_cmd_ready;
  logic                w_rd_is_last;
  logic                w_job_done;
  logic                w_tmo_expire;

  // r_alive keeps cmd_ready low while reset is held and for the first edge after.
  assign w_cmd_ready  = r_alive && (r_state == IDLE);
  assign w_rd_is_last = (r_rd_idx == RD_W'(OUT_DEPTH - 1));
  assign w_job_done   = (r_state == RD_PUSH) && bus.m_ready && w_rd_is_last;

  sa_seq_timeout #(.CNT_W(TMO_W)) u_timeout (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (r_state == START),
    .i_load_val (TMO_W'(TIMEOUT_CYC)),
    .i_en       (r_state == WAIT_DONE),
    .o_expire   (w_tmo_expire)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt_state;
  end

  // Next state and next values of every registered output and counter.
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_en_I     = 1'b0;
    w_nxt_addr_I   = r_addr_I;
    w_nxt_data_I   = r_data_I;
    w_nxt_en_AB    = 1'b0;
    w_nxt_addr_AB  = r_addr_AB;
    w_nxt_data_A   = r_data_A;
    w_nxt_data_B   = r_data_B;
    w_nxt_en_O     = 1'b0;
    w_nxt_addr_O   = r_addr_O;
    w_nxt_ap_start = r_ap_start;
    w_nxt_m_valid  = r_m_valid;
    w_nxt_m_data   = r_m_data;
    w_nxt_m_ok     = r_m_ok;
    w_nxt_m_last   = r_m_last;
    w_nxt_err      = r_err;
    w_nxt_job_idx  = r_job_idx;
    w_nxt_beat     = r_beat;
    w_nxt_rd_idx   = r_rd_idx;
    case (r_state)
      IDLE: begin
        if (bus.cmd_valid && w_cmd_ready) begin
          if (bus.cmd_inst == '0) begin
            w_nxt_err = 1'b1;
          end else begin
            w_nxt_en_I   = 1'b1;
            w_nxt_addr_I = ADDR_W'(r_job_idx);
            w_nxt_data_I = bus.cmd_inst;
            w_nxt_err    = 1'b0;
            w_nxt_beat   = '0;
            w_nxt_state  = LOAD_AB;
          end
        end
      end
      LOAD_AB: begin
        if (bus.s_valid) begin
          w_nxt_en_AB   = 1'b1;
          w_nxt_addr_AB = ADDR_W'(r_beat);
          w_nxt_data_A  = bus.s_data_a;
          w_nxt_data_B  = bus.s_data_b;
          if (r_beat == BEAT_W'(NBEAT - 1)) w_nxt_state = START;
          else                              w_nxt_beat  = r_beat + 1'b1;
        end
      end
      START: begin
        w_nxt_ap_start = 1'b1;
        w_nxt_state    = WAIT_DONE;
      end
      WAIT_DONE: begin
        // A done arriving in the expiry cycle still counts as completion.
        if (bus.ap_done) begin
          w_nxt_ap_start = 1'b0;
          w_nxt_rd_idx   = '0;
          w_nxt_state    = RD_REQ;
        end else if (w_tmo_expire) begin
          w_nxt_ap_start = 1'b0;
          w_nxt_err      = 1'b1;
          w_nxt_state    = IDLE;
        end
      end
      RD_REQ: begin
        w_nxt_en_O   = 1'b1;
        w_nxt_addr_O = ADDR_W'(r_rd_idx);
        w_nxt_state  = RD_CAP;
      end
      RD_CAP: begin
        w_nxt_m_valid = 1'b1;
        w_nxt_m_data  = bus.data_O;
        w_nxt_m_ok    = bus.out_valid;
        w_nxt_m_last  = w_rd_is_last;
        w_nxt_state   = RD_PUSH;
      end
      RD_PUSH: begin
        if (bus.m_ready) begin
          w_nxt_m_valid = 1'b0;
          w_nxt_m_last  = 1'b0;
          if (w_rd_is_last) begin
            w_nxt_job_idx = (r_job_idx == JOB_W'(INST_DEPTH - 1)) ? '0 : r_job_idx + 1'b1;
            w_nxt_state   = IDLE;
          end else begin
            w_nxt_rd_idx = r_rd_idx + 1'b1;
            w_nxt_state  = RD_REQ;
          end
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  // Registered outputs, job index and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alive    <= 1'b0;
      r_en_I     <= 1'b0;
      r_addr_I   <= '0;
      r_data_I   <= '0;
      r_en_AB    <= 1'b0;
      r_addr_AB  <= '0;
      r_data_A   <= '0;
      r_data_B   <= '0;
      r_en_O     <= 1'b0;
      r_addr_O   <= '0;
      r_ap_start <= 1'b0;
      r_m_valid  <= 1'b0;
      r_m_data   <= '0;
      r_m_ok     <= 1'b0;
      r_m_last   <= 1'b0;
      r_err      <= 1'b0;
      r_job_idx  <= '0;
      r_beat     <= '0;
      r_rd_idx   <= '0;
    end else begin
      r_alive    <= 1'b1;
      r_en_I     <= w_nxt_en_I;
      r_addr_I   <= w_nxt_addr_I;
      r_data_I   <= w_nxt_data_I;
      r_en_AB    <= w_nxt_en_AB;
      r_addr_AB  <= w_nxt_addr_AB;
      r_data_A   <= w_nxt_data_A;
      r_data_B   <= w_nxt_data_B;
      r_en_O     <= w_nxt_en_O;
      r_addr_O   <= w_nxt_addr_O;
      r_ap_start <= w_nxt_ap_start;
      r_m_valid  <= w_nxt_m_valid;
      r_m_data   <= w_nxt_m_data;
      r_m_ok     <= w_nxt_m_ok;
      r_m_last   <= w_nxt_m_last;
      r_err      <= w_nxt_err;
      r_job_idx  <= w_nxt_job_idx;
      r_beat     <= w_nxt_beat;
      r_rd_idx   <= w_nxt_rd_idx;
    end
  end

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.s_ready   = (r_state == LOAD_AB);
  assign bus.busy      = (r_state != IDLE);
  assign bus.en_I      = r_en_I;
  assign bus.addr_I    = r_addr_I;
  assign bus.data_I    = r_data_I;
  assign bus.en_A      = r_en_AB;
  assign bus.en_B      = r_en_AB;
  assign bus.addr_A    = r_addr_AB;
  assign bus.addr_B    = r_addr_AB;
  assign bus.data_A    = r_data_A;
  assign bus.data_B    = r_data_B;
  assign bus.en_O      = r_en_O;
  assign bus.addr_O    = r_addr_O;
  assign bus.ap_start  = r_ap_start;
  assign bus.m_valid   = r_m_valid;
  assign bus.m_data    = r_m_data;
  assign bus.m_ok      = r_m_ok;
  assign bus.m_last    = r_m_last;
  assign bus.err       = r_err;
  assign o_dbg_state   = r_state;

`ifdef SA_SEQ_PERF_EN
  logic [31:0] r_perf_cycles;
  logic [15:0] r_perf_jobs;

  // Saturating compute-cycle count and completed-job count, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_cycles <= '0;
      r_perf_jobs   <= '0;
    end else begin
      if (r_ap_start && (r_perf_cycles != '1)) r_perf_cycles <= r_perf_cycles + 1'b1;
      if (w_job_done)                          r_perf_jobs   <= r_perf_jobs + 1'b1;
    end
  end

  assign perf_cycles = r_perf_cycles;
  assign perf_jobs   = r_perf_jobs;
`else
  logic w_unused_job_done;
  assign w_unused_job_done = w_job_done;
`endif

endmodule

// File: tb/tb_sa_host_sequencer.sv
// Self-checking bench for sa_host_sequencer: a table of jobs (legal and
// illegal commands, stall and backpressure modes) plus hand-written timeout
// and mid-readback reset sequences. Expected writes and readback beats are
// queued when stimulus is driven and compared when the DUT produces them.
module tb_sa_host_sequencer;
  import sa_seq_pkg::*;

  localparam int NB    = 64;
  localparam int DEPTH = 256;
  localparam int IW    = 14;   // {addr_I, data_I}
  localparam int AW    = 48;   // {addr_A, addr_B, data_A, data_B}
  localparam int MW    = 18;   // {m_ok, m_last, m_data}

  logic clk;
  logic rst_n;
  state_t dbg_state;
  state_t to_dbg_state;

  sa_host_sequencer_if #(.DATA_W(16), .ADDR_W(8), .INST_W(6)) bus ();
  sa_host_sequencer_if #(.DATA_W(16), .ADDR_W(8), .INST_W(6)) to_bus ();

`ifdef SA_SEQ_PERF_EN
  logic [31:0] perf_cycles, to_perf_cycles;
  logic [15:0] perf_jobs, to_perf_jobs;
`endif

  sa_host_sequencer #(.DATA_W(16), .DIM(8), .OUT_DEPTH(DEPTH), .ADDR_W(8),
                      .INST_W(6), .INST_DEPTH(16), .TIMEOUT_CYC(4096)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .o_dbg_state(dbg_state)
`ifdef SA_SEQ_PERF_EN
    , .perf_cycles(perf_cycles), .perf_jobs(perf_jobs)
`endif
  );

  // Small instance used only for the completion-timeout sequence.
  sa_host_sequencer #(.DATA_W(16), .DIM(2), .OUT_DEPTH(4), .ADDR_W(8),
                      .INST_W(6), .INST_DEPTH(16), .TIMEOUT_CYC(32)) dut_to (
    .clk(clk), .rst_n(rst_n), .bus(to_bus), .o_dbg_state(to_dbg_state)
`ifdef SA_SEQ_PERF_EN
    , .perf_cycles(to_perf_cycles), .perf_jobs(to_perf_jobs)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [IW-1:0] exp_i_q[$];
  logic [AW-1:0] exp_a_q[$];
  logic [MW-1:0] exp_m_q[$];
  int  m_rx;
  int  rd_exp;
  int  m_mode;
  logic mon_en;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_o(input logic [7:0] a);
    return ({8'h00, a} * 16'd3) + 16'h1234;
  endfunction

  // ---------------- top model ----------------
  // Output buffer reads combinationally; ap_done follows 50 cycles of ap_start.
  assign bus.data_O    = mem_o(bus.addr_O);
  assign bus.out_valid = bus.en_O;

  int st_cnt;
  always @(posedge clk) begin
    #2;
    if (bus.ap_start) begin
      st_cnt++;
      bus.ap_done = (st_cnt == 50);
    end else begin
      st_cnt      = 0;
      bus.ap_done = 1'b0;
    end
  end

  // Downstream sink: 0 = always ready, 1 = 1/3 duty, 2 = random.
  int cyc;
  always @(posedge clk) begin
    #2;
    cyc++;
    case (m_mode)
      1:       bus.m_ready = (cyc % 3 == 0);
      2:       bus.m_ready = ($urandom_range(0, 1) == 1);
      default: bus.m_ready = 1'b1;
    endcase
  end

  // ---------------- monitor / scoreboard ----------------
  logic          prev_hold;
  logic [MW-1:0] prev_pay;
  logic [IW-1:0] e_i;
  logic [AW-1:0] e_a;
  logic [MW-1:0] e_m;
  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      prev_hold = 1'b0;
    end else begin
      if (bus.en_I) begin
        check("en_I_expected", 64'(exp_i_q.size() != 0), 64'(1));
        if (exp_i_q.size() != 0) begin
          e_i = exp_i_q.pop_front();
          check("en_I_write", 64'({bus.addr_I, bus.data_I}), 64'(e_i));
        end
      end
      if (bus.en_A || bus.en_B) begin
        check("en_AB_pair", 64'({bus.en_A, bus.en_B}), 64'(2'b11));
        check("en_A_expected", 64'(exp_a_q.size() != 0), 64'(1));
        if (exp_a_q.size() != 0) begin
          e_a = exp_a_q.pop_front();
          check("en_A_write", 64'({bus.addr_A, bus.addr_B, bus.data_A, bus.data_B}), 64'(e_a));
        end
      end
      if (bus.en_O) begin
        check("addr_O", 64'(bus.addr_O), 64'(rd_exp));
        rd_exp++;
      end
      if (prev_hold)
        check("m_hold", 64'({bus.m_valid, bus.m_ok, bus.m_last, bus.m_data}), 64'({1'b1, prev_pay}));
      if (bus.m_valid && bus.m_ready) begin
        check("m_expected", 64'(exp_m_q.size() != 0), 64'(1));
        if (exp_m_q.size() != 0) begin
          e_m = exp_m_q.pop_front();
          check("m_beat", 64'({bus.m_ok, bus.m_last, bus.m_data}), 64'(e_m));
        end
        m_rx++;
      end
      prev_hold = bus.m_valid && !bus.m_ready;
      prev_pay  = {bus.m_ok, bus.m_last, bus.m_data};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 64'({bus.cmd_ready, bus.s_ready, bus.en_A, bus.en_B, bus.en_I, bus.en_O,
                              bus.ap_start, bus.m_valid, bus.m_ok, bus.m_last, bus.busy, bus.err}), 64'(0));
    check({tag, "_addr"}, 64'({bus.addr_A, bus.addr_B, bus.addr_I, bus.addr_O}), 64'(0));
    check({tag, "_data"}, 64'({bus.data_A, bus.data_B, bus.data_I, bus.m_data}), 64'(0));
    check({tag, "_to_ctl"}, 64'({to_bus.cmd_ready, to_bus.ap_start, to_bus.busy, to_bus.err,
                                 to_bus.m_valid, to_bus.en_A, to_bus.en_I}), 64'(0));
    check({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
  endtask

  task automatic send_cmd(input logic [5:0] inst, output bit ok);
    int g;
    g = 0;
    while (!bus.cmd_ready && g < 100) begin
      @(posedge clk); #2; g++;
    end
    ok = bus.cmd_ready;
    check("cmd_ready_wait", 64'(ok), 64'(1));
    bus.cmd_valid = 1'b1;
    bus.cmd_inst  = inst;
    @(posedge clk); #2;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_illegal();
    bit ok;
    send_cmd(6'd0, ok);
    check("illegal_err", 64'(bus.err), 64'(1));
    check("illegal_idle", 64'({bus.busy, bus.cmd_ready}), 64'(2'b01));
    repeat (3) @(posedge clk);
    #2;
  endtask

  // One full job; abort_at >= 0 asserts reset once that many beats are read.
  task automatic run_job(input logic [5:0] inst, input int s_mode, input int mm,
                         input logic [7:0] exp_ai, input int abort_at);
    bit ok;
    int k, g;
    logic [15:0] off, a, b;
    m_mode = mm;
    m_rx   = 0;
    rd_exp = 0;
    off    = {2'b00, inst - 6'd1, 8'h00};
    exp_i_q.push_back({exp_ai, inst});
    for (int j = 0; j < DEPTH; j++)
      exp_m_q.push_back({1'b1, (j == DEPTH - 1), mem_o(8'(j))});
    send_cmd(inst, ok);
    check("cmd_clears_err", 64'({bus.err, bus.busy}), 64'(2'b01));
    k = 0; g = 0;
    while (k < NB && g < 2000) begin
      if (bus.s_ready && (s_mode == 0 || $urandom_range(0, 1) == 1)) begin
        a = off + 16'(k);
        b = off + 16'(k) + 16'd100;
        bus.s_valid  = 1'b1;
        bus.s_data_a = a;
        bus.s_data_b = b;
        exp_a_q.push_back({8'(k), 8'(k), a, b});
        k++;
      end else begin
        bus.s_valid = 1'b0;
      end
      @(posedge clk); #2; g++;
    end
    bus.s_valid = 1'b0;
    check("load_beats", 64'(k), 64'(NB));
    g = 0;
    while (!(m_rx == DEPTH && !bus.busy) && g < 20000) begin
      if (abort_at >= 0 && m_rx >= abort_at) begin
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        exp_i_q.delete(); exp_a_q.delete(); exp_m_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        return;
      end
      @(posedge clk); #2; g++;
    end
    check("job_beats", 64'(m_rx), 64'(DEPTH));
    check("job_idle", 64'({bus.busy, bus.err}), 64'(0));
    check("job_q_empty", 64'(exp_i_q.size() + exp_a_q.size() + exp_m_q.size()), 64'(0));
    check("job_state", 64'(dbg_state), 64'(IDLE));
  endtask

  // ---------------- test table ----------------
  typedef struct {
    logic [5:0] inst;     // 0 = illegal command
    int         s_mode;   // 0 = s_valid whenever ready, 1 = random 50%
    int         m_mode;
    logic [7:0] exp_ai;   // expected addr_I of the en_I write
  } vec_t;

  vec_t vecs[18];

  initial begin
    int legal;
    int cnt;
    bit ok;
    rst_n = 1'b0;
    mon_en = 1'b0;
    m_mode = 0;
    bus.cmd_valid = 1'b0; bus.cmd_inst = '0;
    bus.s_valid = 1'b0; bus.s_data_a = '0; bus.s_data_b = '0;
    to_bus.cmd_valid = 1'b0; to_bus.cmd_inst = '0;
    to_bus.s_valid = 1'b0; to_bus.s_data_a = '0; to_bus.s_data_b = '0;
    to_bus.data_O = '0; to_bus.out_valid = 1'b0; to_bus.ap_done = 1'b0; to_bus.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #2;
    mon_en = 1'b1;

    legal = 0;
    for (int i = 0; i < 18; i++) begin
      if (i == 3) begin
        vecs[i] = '{inst: 6'd0, s_mode: 0, m_mode: 0, exp_ai: 8'd0};
      end else begin
        vecs[i].inst   = 6'(legal + 1);
        vecs[i].s_mode = (i == 2) ? 1 : (i % 2);
        vecs[i].m_mode = (i == 1) ? 1 : (i % 3);
        vecs[i].exp_ai = 8'(legal % 16);
        legal++;
      end
    end
    vecs[0].s_mode = 0;
    vecs[0].m_mode = 0;

    for (int i = 0; i < 18; i++) begin
      if (vecs[i].inst == 6'd0) run_illegal();
      else run_job(vecs[i].inst, vecs[i].s_mode, vecs[i].m_mode, vecs[i].exp_ai, -1);
    end

    // Completion timeout on the small instance: ap_done never arrives.
    cnt = 0;
    while (!to_bus.cmd_ready && cnt < 100) begin @(posedge clk); #2; cnt++; end
    to_bus.cmd_valid = 1'b1; to_bus.cmd_inst = 6'd5;
    @(posedge clk); #2;
    to_bus.cmd_valid = 1'b0;
    cnt = 0;
    for (int g = 0; g < 50 && cnt < 4; g++) begin
      if (to_bus.s_ready) begin to_bus.s_valid = 1'b1; to_bus.s_data_a = 16'(g); cnt++; end
      else to_bus.s_valid = 1'b0;
      @(posedge clk); #2;
    end
    to_bus.s_valid = 1'b0;
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #2;
      if (to_bus.ap_start) cnt++;
      else if (cnt > 0) break;
    end
    check("tmo_start_cycles", 64'(cnt), 64'(32));
    check("tmo_flags", 64'({to_bus.ap_start, to_bus.err, to_bus.busy}), 64'(3'b010));
    check("tmo_state", 64'(to_dbg_state), 64'(IDLE));
    to_bus.cmd_valid = 1'b1; to_bus.cmd_inst = 6'd2;
    @(posedge clk); #2;
    to_bus.cmd_valid = 1'b0;
    check("tmo_err_cleared", 64'({to_bus.err, to_bus.busy}), 64'(2'b01));

    // Reset in the middle of readback, then a fresh job from job index 0.
    run_job(6'd9, 0, 0, 8'd1, 100);
    check("midrst_released", 64'({bus.busy, bus.err}), 64'(0));
    run_job(6'd10, 1, 2, 8'd0, -1);

    send_cmd(6'd0, ok);
    check("final_illegal_err", 64'(bus.err), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
